// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi decoder.
// Trellis geometry and survivor-memory sizing live here.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int S_W        = K - 1;
  localparam int TB_DEPTH   = 8;
  localparam int PTR_W      = $clog2(TB_DEPTH);

  typedef logic [S_W-1:0]        state_t;
  typedef logic [NUM_STATES-1:0] dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } tb_state_e;

endpackage

// File: rtl/viterbi_tb_step.sv
// One traceback step: selects the surviving predecessor
// of a state from its stored decision vector.
module viterbi_tb_step
  import viterbi_pkg::*;
(
  input  state_t i_s,
  input  dec_t   i_dec,
  output state_t o_pred
);

  assign o_pred = {i_s[S_W-2:0], i_dec[i_s]};

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the Viterbi decoder.
// Stores decision vectors circularly, emits one decoded bit per en_t.
module viterbi_traceback
  import viterbi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en_m,
  input  logic             i_en_t,
  input  logic [NUM_STATES-1:0] i_dec,
  input  logic [S_W-1:0]   i_best_state,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_err,
  output logic [PTR_W:0]   o_fill,
  output logic [15:0]      o_bit_cnt
);

  if (TB_DEPTH < 2) begin : g_bad_depth
    $error("viterbi_traceback: TB_DEPTH must be at least 2");
  end

  dec_t             r_mem [TB_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_fill;
  tb_state_e        r_state;
  tb_state_e        w_state_nxt;
  logic             w_full;
  state_t           w_s [TB_DEPTH];

  localparam logic [PTR_W:0] FILL_MAX = (PTR_W+1)'(TB_DEPTH);

  assign w_full = (r_state == ST_FULL);
  assign w_s[0] = i_best_state;

  // Walk back from the newest entry; reads see pre-write contents.
  for (genvar k = 1; k < TB_DEPTH; k++) begin : g_chain
    logic [PTR_W-1:0] w_idx;
    assign w_idx = r_wr_ptr - PTR_W'(k);
    viterbi_tb_step u_step (
      .i_s    (w_s[k-1]),
      .i_dec  (r_mem[w_idx]),
      .o_pred (w_s[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (i_en_m) w_state_nxt = ST_FILL;
      ST_FILL:
        if (i_en_m && r_fill == FILL_MAX - 1'b1)
          w_state_nxt = ST_FULL;
      ST_FULL:  w_state_nxt = ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TB_DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_state   <= ST_EMPTY;
      o_bit     <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_en_m) begin
        r_mem[r_wr_ptr] <= i_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (r_fill != FILL_MAX)
          r_fill <= r_fill + 1'b1;
      end
      o_valid <= i_en_t && w_full;
      o_err   <= i_en_t && !w_full;
      if (i_en_t && w_full) begin
        o_bit     <= w_s[TB_DEPTH-1][S_W-1];
        o_bit_cnt <= o_bit_cnt + 16'd1;
      end
    end
  end

  assign o_fill = r_fill;

endmodule
